// File: rtl/tx_pkt_fifo_pkg.sv
// tx_pkt_fifo_pkg
// Shared definitions for the transmit store-and-forward packet FIFO:
//   - beat field widths and the 74-bit stored entry layout {tuser, tlast, tkeep, tdata}
//   - write-side FSM state encoding
package tx_pkt_fifo_pkg;

    localparam int DATA_W  = 64;
    localparam int KEEP_W  = 8;
    localparam int ENTRY_W = DATA_W + KEEP_W + 2;

    // Packed so that the entry casts directly to/from a RAM word.
    typedef struct packed {
        logic              tuser;
        logic              tlast;
        logic [KEEP_W-1:0] tkeep;
        logic [DATA_W-1:0] tdata;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DROP  = 2'd2
    } wr_state_t;

endpackage

// File: rtl/tx_pkt_fifo_if.sv
// tx_pkt_fifo_if
// AXI4-Stream beat bundle used on both sides of the packet FIFO.
//   master modport: drives tdata/tkeep/tvalid/tlast/tuser, receives tready
//   slave  modport: receives tdata/tkeep/tvalid/tlast/tuser, drives tready
interface tx_pkt_fifo_if;
    import tx_pkt_fifo_pkg::*;

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic              tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/tx_pkt_fifo_ram.sv
// tx_pkt_fifo_ram
// Simple dual-port RAM: one write port, one read port with a registered read.
// The read register only updates when i_re is high, so it holds the last word
// while the consumer stalls; it clears on reset.
//   clk, rst   : clock, synchronous active-high reset (read register only)
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr         : read port, data appears on o_rdata after the edge
module tx_pkt_fifo_ram #(
    parameter int ADDR_W = 11,
    parameter int WIDTH  = 74
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);
    logic [WIDTH-1:0] r_mem [2**ADDR_W];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/tx_pkt_fifo.sv
// tx_pkt_fifo
// Store-and-forward packet FIFO in front of the MAC transmit path. A frame is
// only made visible to the egress side once its last beat is stored, so the
// transmitter never underruns mid-frame. Frames larger than the FIFO are
// accepted and discarded.
// Optional feature macro TX_PKT_FIFO_DROP_BAD_EN: when defined, frames whose
// last beat carries tuser=1 are discarded and m_axis.tuser is always 0; when
// undefined, tuser is carried to the egress last beat.
//   clk, rst    : clock, synchronous active-high reset
//   s_axis      : ingress AXIS (slave)
//   m_axis      : egress AXIS (master), first-word-fall-through
//   pkt_dropped : one-cycle pulse per discarded frame
//   fifo_level  : committed words not yet read
module tx_pkt_fifo
    import tx_pkt_fifo_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    tx_pkt_fifo_if.slave      s_axis,
    tx_pkt_fifo_if.master     m_axis,
    output logic              pkt_dropped,
    output logic [ADDR_W:0]   fifo_level
);
    typedef logic [ADDR_W:0] ptr_t;

    localparam int   DEPTH   = 2**ADDR_W;
    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
    localparam ptr_t PTR_ONE = ptr_t'(1);

    wr_state_t r_state, w_state_next;
    ptr_t      r_wr_ptr, w_wr_ptr_next;
    ptr_t      r_commit_ptr, w_commit_ptr_next;
    ptr_t      r_rd_ptr, w_rd_ptr_next;
    ptr_t      r_level;
    logic      r_out_vld, w_out_vld_next;
    logic      r_pkt_dropped, w_drop_next;
    logic      w_full, w_s_ready, w_wr_acc, w_we, w_re, w_bad_last;
    entry_t    w_wr_entry, w_rd_entry;
    logic [ENTRY_W-1:0] w_rd_word;

    // Pointers carry one extra bit so a completely full buffer is
    // distinguishable from an empty one.
    assign w_full    = (r_wr_ptr - r_rd_ptr) == DEPTH_P;
    // DROP keeps accepting even when full: those beats are thrown away.
    assign w_s_ready = !rst && (!w_full || r_state == ST_DROP);
    assign w_wr_acc  = s_axis.tvalid && w_s_ready;
    assign s_axis.tready = w_s_ready;

`ifdef TX_PKT_FIFO_DROP_BAD_EN
    assign w_bad_last       = s_axis.tuser;
    assign w_wr_entry.tuser = 1'b0;
`else
    assign w_bad_last       = 1'b0;
    // tuser only has meaning on the last beat; mask it elsewhere.
    assign w_wr_entry.tuser = s_axis.tuser & s_axis.tlast;
`endif
    assign w_wr_entry.tlast = s_axis.tlast;
    assign w_wr_entry.tkeep = s_axis.tkeep;
    assign w_wr_entry.tdata = s_axis.tdata;

    always_comb begin
        w_state_next      = r_state;
        w_wr_ptr_next     = r_wr_ptr;
        w_commit_ptr_next = r_commit_ptr;
        w_we              = 1'b0;
        w_drop_next       = 1'b0;
        case (r_state)
            ST_IDLE, ST_WRITE: begin
                if (w_wr_acc) begin
                    w_we          = 1'b1;
                    w_wr_ptr_next = r_wr_ptr + PTR_ONE;
                    if (s_axis.tlast) begin
                        w_state_next = ST_IDLE;
                        if (w_bad_last) begin
                            // Rewind over the bad frame instead of committing it.
                            w_wr_ptr_next = r_commit_ptr;
                            w_drop_next   = 1'b1;
                        end else begin
                            w_commit_ptr_next = r_wr_ptr + PTR_ONE;
                        end
                    end else begin
                        w_state_next = ST_WRITE;
                    end
                end else if (r_state == ST_WRITE && w_full && r_commit_ptr == r_rd_ptr) begin
                    // Nothing committed is left to drain, so this frame alone
                    // fills the buffer and can never fit: discard it.
                    w_state_next  = ST_DROP;
                    w_wr_ptr_next = r_commit_ptr;
                end
            end
            ST_DROP: begin
                if (w_wr_acc && s_axis.tlast) begin
                    w_state_next = ST_IDLE;
                    w_drop_next  = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The RAM read register is the egress output register: fetch the next
    // committed word whenever that register is empty or being consumed.
    assign w_re           = (r_commit_ptr != r_rd_ptr) && (!r_out_vld || m_axis.tready);
    assign w_rd_ptr_next  = w_re ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
    assign w_out_vld_next = w_re ? 1'b1 : (m_axis.tready ? 1'b0 : r_out_vld);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_wr_ptr      <= '0;
            r_commit_ptr  <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_out_vld     <= 1'b0;
            r_pkt_dropped <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_wr_ptr      <= w_wr_ptr_next;
            r_commit_ptr  <= w_commit_ptr_next;
            r_rd_ptr      <= w_rd_ptr_next;
            r_level       <= w_commit_ptr_next - w_rd_ptr_next;
            r_out_vld     <= w_out_vld_next;
            r_pkt_dropped <= w_drop_next;
        end
    end

    tx_pkt_fifo_ram #(
        .ADDR_W (ADDR_W),
        .WIDTH  (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[ADDR_W-1:0]),
        .i_wdata (w_wr_entry),
        .i_re    (w_re),
        .i_raddr (r_rd_ptr[ADDR_W-1:0]),
        .o_rdata (w_rd_word)
    );

    assign w_rd_entry    = entry_t'(w_rd_word);
    assign m_axis.tdata  = w_rd_entry.tdata;
    assign m_axis.tkeep  = w_rd_entry.tkeep;
    assign m_axis.tlast  = w_rd_entry.tlast;
    assign m_axis.tuser  = w_rd_entry.tuser;
    assign m_axis.tvalid = r_out_vld;
    assign pkt_dropped   = r_pkt_dropped;
    assign fifo_level    = r_level;
endmodule

// File: tb/tb_tx_pkt_fifo.sv
module tb_tx_pkt_fifo;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2**ADDR_W;

    logic            clk = 1'b0;
    logic            rst;
    logic            pkt_dropped;
    logic [ADDR_W:0] fifo_level;

    tx_pkt_fifo_if s_if ();
    tx_pkt_fifo_if m_if ();

    tx_pkt_fifo #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .pkt_dropped (pkt_dropped),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic        u;
    } beat_t;

    int total = 0;
    int bad   = 0;

    beat_t exp_q[$];
    beat_t cur_q[$];
    int committed = 0, delivered = 0, pend_drop = 0, drop_seen = 0;
    int tlast_seen = 0, tuser_seen = 0, cyc = 0;
    int last_commit_cyc = 0, first_valid_cyc = 0, max_level = 0;
    int rdy_mode = 0;
    logic prev_stall = 1'b0, prev_mid = 1'b0, prev_vld = 1'b0;
    beat_t prev_beat;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Egress consumer: tready pattern chosen by the running test.
    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = 1'($urandom_range(0, 1));
                default: m_if.tready = 1'b0;
            endcase
        end
    end

    // Reference model and per-cycle comparison. Values seen at a falling edge
    // describe what happens at the next rising edge.
    always @(negedge clk) begin : cmp
        beat_t e, b;
        logic  drop;
        cyc++;
        if (rst) begin
            exp_q.delete();
            cur_q.delete();
            committed  = 0;
            delivered  = 0;
            pend_drop  = 0;
            prev_stall = 1'b0;
            prev_mid   = 1'b0;
            prev_vld   = 1'b0;
        end else begin
            // Committed words not yet read out of the buffer.
            check("level", 64'(fifo_level), 64'(committed - delivered - int'(m_if.tvalid)));
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
            if (prev_stall) begin
                check("hold_valid", 64'(m_if.tvalid), 64'd1);
                check("hold_data", m_if.tdata, prev_beat.d);
                check("hold_ctl", 64'({m_if.tkeep, m_if.tlast, m_if.tuser}),
                      64'({prev_beat.k, prev_beat.l, prev_beat.u}));
            end
            if (prev_mid) check("no_gap", 64'(m_if.tvalid), 64'd1);
            if (m_if.tvalid && !prev_vld) first_valid_cyc = cyc;
            if (pkt_dropped) begin
                check("drop_expected", 64'(pend_drop > 0), 64'd1);
                if (pend_drop > 0) pend_drop--;
                drop_seen++;
            end

            prev_mid = 1'b0;
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL egress_unexpected: got beat %h required none (cycle %0d)", m_if.tdata, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("egress_data", m_if.tdata, e.d);
                    check("egress_keep", 64'(m_if.tkeep), 64'(e.k));
                    check("egress_last", 64'(m_if.tlast), 64'(e.l));
                    check("egress_user", 64'(m_if.tuser), 64'(e.u));
                end
                delivered++;
                if (m_if.tlast) tlast_seen++;
                if (m_if.tuser) tuser_seen++;
                prev_mid = !m_if.tlast;
            end
            prev_stall  = m_if.tvalid && !m_if.tready;
            prev_vld    = m_if.tvalid;
            prev_beat.d = m_if.tdata;
            prev_beat.k = m_if.tkeep;
            prev_beat.l = m_if.tlast;
            prev_beat.u = m_if.tuser;

            if (s_if.tvalid && s_if.tready) begin
                b.d = s_if.tdata;
                b.k = s_if.tkeep;
                b.l = s_if.tlast;
`ifdef TX_PKT_FIFO_DROP_BAD_EN
                b.u = 1'b0;
`else
                b.u = s_if.tlast & s_if.tuser;
`endif
                cur_q.push_back(b);
                if (s_if.tlast) begin
                    drop = cur_q.size() > DEPTH;
`ifdef TX_PKT_FIFO_DROP_BAD_EN
                    if (s_if.tuser) drop = 1'b1;
`endif
                    if (drop) begin
                        pend_drop++;
                    end else begin
                        foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                        committed += cur_q.size();
                        last_commit_cyc = cyc;
                    end
                    cur_q.delete();
                end
            end
        end
    end

    // Tasks start and end just after a rising edge.
    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        int n = 0;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        s_if.tuser  = u;
        s_if.tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_if.tready) break;
            n++;
            if (n > 5000) begin
                total++;
                bad++;
                $display("FAIL ingress_timeout: tready low for %0d cycles, required accept", n);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        s_if.tvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int len, input logic [7:0] lastk, input logic u, input int gap_pct);
        for (int i = 0; i < len; i++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
            if (i == len - 1) send_beat({$urandom, $urandom}, lastk, 1'b1, u);
            else              send_beat({$urandom, $urandom}, 8'hFF, 1'b0, 1'($urandom_range(0, 1)));
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_if.tvalid && pend_drop == 0) break;
            n++;
            if (n > 5000) break;
        end
        check("drain_in_time", 64'(n <= 5000), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d0, t0, dr0, u0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tvalid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", 64'(s_if.tready), 64'd0);
        check("rst_m_valid", 64'(m_if.tvalid), 64'd0);
        check("rst_m_data", m_if.tdata, 64'd0);
        check("rst_m_ctl", 64'({m_if.tkeep, m_if.tlast, m_if.tuser}), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_dropped", 64'(pkt_dropped), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(s_if.tready), 64'd1);
        @(posedge clk);
        #1;

        // Single 8-beat frame, short last beat, egress always ready.
        rdy_mode  = 0;
        max_level = 0;
        send_frame(8, 8'h0F, 1'b0, 0);
        wait_drain();
        check("t1_latency", 64'(first_valid_cyc - last_commit_cyc), 64'd2);
        check("t1_level_peak", 64'(max_level), 64'd8);
        check("t1_delivered", 64'(delivered), 64'd8);
        check("t1_level_end", 64'(fifo_level), 64'd0);

        // Ingress stalls mid-frame: nothing may leave before the last beat.
        d0 = delivered;
        for (int i = 0; i < 3; i++) send_beat({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0);
        idle(20);
        check("t2_no_early_egress", 64'(delivered - d0), 64'd0);
        check("t2_no_early_valid", 64'(m_if.tvalid), 64'd0);
        for (int i = 0; i < 5; i++) send_beat({$urandom, $urandom}, (i == 4) ? 8'h3F : 8'hFF, i == 4, 1'b0);
        s_if.tvalid = 1'b0;
        wait_drain();
        check("t2_delivered", 64'(delivered - d0), 64'd8);

        // Ten back-to-back 64-byte frames, egress ready toggling randomly.
        rdy_mode = 1;
        d0 = delivered; t0 = tlast_seen; dr0 = drop_seen;
        for (int f = 0; f < 10; f++) send_frame(8, 8'hFF, 1'b0, 0);
        wait_drain();
        check("t3_beats", 64'(delivered - d0), 64'd80);
        check("t3_frames", 64'(tlast_seen - t0), 64'd10);
        check("t3_drops", 64'(drop_seen - dr0), 64'd0);

        // Oversized frame is discarded, the next one passes.
        rdy_mode = 0;
        d0 = delivered; dr0 = drop_seen;
        send_frame(20, 8'hFF, 1'b0, 0);
        send_frame(4, 8'h01, 1'b0, 0);
        wait_drain();
        check("t4_drops", 64'(drop_seen - dr0), 64'd1);
        check("t4_delivered", 64'(delivered - d0), 64'd4);

        // Egress blocked with two committed frames filling the buffer.
        rdy_mode = 2;
        d0 = delivered; dr0 = drop_seen;
        send_frame(8, 8'hFF, 1'b0, 0);
        send_frame(9, 8'h07, 1'b0, 0);
        s_if.tdata  = 64'h0123_4567_89AB_CDEF;
        s_if.tkeep  = 8'hFF;
        s_if.tlast  = 1'b0;
        s_if.tvalid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("t5_full_ready", 64'(s_if.tready), 64'd0);
        end
        check("t5_full_level", 64'(fifo_level), 64'd16);
        check("t5_no_drop", 64'(drop_seen - dr0), 64'd0);
        @(posedge clk);
        #1;
        rdy_mode = 0;
        send_frame(4, 8'hFF, 1'b0, 0);
        wait_drain();
        check("t5_delivered", 64'(delivered - d0), 64'd21);
        check("t5_no_drop_end", 64'(drop_seen - dr0), 64'd0);

        // Three frames, the middle one flagged bad on its last beat.
        d0 = delivered; dr0 = drop_seen; u0 = tuser_seen;
        send_frame(5, 8'hFF, 1'b0, 0);
        send_frame(5, 8'h1F, 1'b1, 0);
        send_frame(5, 8'hFF, 1'b0, 0);
        wait_drain();
`ifdef TX_PKT_FIFO_DROP_BAD_EN
        check("t6_drops", 64'(drop_seen - dr0), 64'd1);
        check("t6_delivered", 64'(delivered - d0), 64'd10);
        check("t6_tuser", 64'(tuser_seen - u0), 64'd0);
`else
        check("t6_drops", 64'(drop_seen - dr0), 64'd0);
        check("t6_delivered", 64'(delivered - d0), 64'd15);
        check("t6_tuser", 64'(tuser_seen - u0), 64'd1);
`endif

        // Random traffic against the model.
        rdy_mode = 1;
        for (int f = 0; f < 40; f++) begin
            int len;
            len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 24)) : int'($urandom_range(1, 16));
            send_frame(len, 8'hFF >> $urandom_range(0, 7), 1'($urandom_range(0, 3) == 0), 20);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 5));
        end
        wait_drain();

        // Reset in the middle of a frame: partial frame is lost.
        rdy_mode = 0;
        for (int i = 0; i < 3; i++) send_beat({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("t8_rst_ready", 64'(s_if.tready), 64'd0);
        @(posedge clk);
        #1;
        s_if.tvalid = 1'b0;
        @(negedge clk);
        check("t8_rst_valid", 64'(m_if.tvalid), 64'd0);
        check("t8_rst_level", 64'(fifo_level), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        d0 = delivered;
        send_frame(4, 8'h0F, 1'b0, 0);
        wait_drain();
        check("t8_delivered", 64'(delivered - d0), 64'd4);

        check("end_queue_empty", 64'(exp_q.size()), 64'd0);
        check("end_pending_drops", 64'(pend_drop), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/tx_pkt_fifo.md
Name: tx_pkt_fifo

Overview:
- Store-and-forward packet FIFO directly upstream of the MAC transmit path.
- Accepts AXIS frames from the user/DMA side and emits them on AXIS into the padding/XGMII transmit stage.
- Releases a frame only once it is fully buffered, so the transmitter never underruns mid-frame.
- Discards frames that cannot fit and, optionally, frames flagged bad by the user.

Parameters:
- ADDR_W, 11, log2 of FIFO depth in 64-bit words (2048 words = 16 KiB, holds a 9600-byte jumbo).
- DEPTH, 2**ADDR_W, derived; not overridden independently.

Ports:
- clk  in  1  core clock, 156.25 MHz
- rst  in  1  synchronous reset, active-high
- s_axis_tdata  in  64  ingress data
- s_axis_tkeep  in  8  ingress byte enables, contiguous from bit 0
- s_axis_tvalid  in  1  ingress valid
- s_axis_tready  out  1  ingress ready
- s_axis_tlast  in  1  ingress end of frame
- s_axis_tuser  in  1  ingress error flag, sampled on tlast beat
- m_axis_tdata  out  64  egress data
- m_axis_tkeep  out  8  egress byte enables
- m_axis_tvalid  out  1  egress valid
- m_axis_tready  in  1  egress ready, from the transmit stage
- m_axis_tlast  out  1  egress end of frame
- m_axis_tuser  out  1  egress error flag
- pkt_dropped  out  1  one-cycle pulse per discarded frame
- fifo_level  out  ADDR_W+1  committed words not yet read

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Storage: entry = {tuser, tlast, tkeep, tdata}, 74 bits. Pointers are ADDR_W+1 bits wide and wrap naturally.
  - wr_ptr: next write address.
  - commit_ptr: end of the last complete accepted frame.
  - rd_ptr: next read address.
- Full: (wr_ptr - rd_ptr) == DEPTH.
- Reset values: all pointers 0; m_axis_tvalid=0; m_axis_tlast=0; m_axis_tuser=0; m_axis_tdata/tkeep=0; pkt_dropped=0; fifo_level=0; state=IDLE.
- s_axis_tready:
  - 0 while rst is high.
  - 1 in the first cycle after reset.
  - Thereafter = !full || state==DROP.
- Write FSM states: IDLE, WRITE, DROP.
  - IDLE --beat accepted, tlast=0--> WRITE.
  - IDLE or WRITE, beat with tlast=1 accepted --> IDLE. commit_ptr <= wr_ptr+1 on the next edge.
  - WRITE, full with commit_ptr==rd_ptr (frame larger than FIFO) --> DROP. wr_ptr <= commit_ptr.
  - DROP: accept and discard every beat; on tlast --> IDLE and pulse pkt_dropped.
  - Full with committed data pending: stall (tready=0); do not drop.
- Read side:
  - Reads only from [rd_ptr, commit_ptr).
  - Output register, first-word-fall-through.
  - Latency: a tlast beat accepted at cycle N gives commit at N+1 and m_axis_tvalid earliest at N+2.
  - Egress frames are back-to-back with zero idle cycles while m_axis_tready=1.
  - m_axis_* hold stable while tvalid=1 and tready=0.
- fifo_level = commit_ptr - rd_ptr, registered; updates the cycle after a commit or read.
- Simultaneous commit and read in the same cycle: both take effect; level reflects the net change.
- Wrap-around: pointer differences are taken modulo 2**(ADDR_W+1).
- Reset mid-frame: the partial frame is lost. Egress drops tvalid immediately with no tlast; the downstream stage is reset by the same rst.

Optional Feature:
- Macro: TX_PKT_FIFO_DROP_BAD_EN.
- Defined: a frame whose tlast beat has tuser=1 is not committed. wr_ptr <= commit_ptr, pkt_dropped pulses, FSM returns to IDLE, and m_axis_tuser is tied 0.
- Undefined: the frame is committed normally and tuser is carried through to m_axis_tuser on the tlast beat; the transmit stage then inserts the error code.

Decomposition:
- Package tx_pkt_fifo_pkg holds:
  - Entry field offsets/widths: DATA_W=64, KEEP_W=8, ENTRY_W=74.
  - Write-FSM state encoding.
- Sub-module tx_pkt_fifo_ram: simple dual-port RAM, 1 write / 1 read port, registered read, inferred BRAM, ENTRY_W x DEPTH.

Test Plan:
- Single 8-beat frame, tkeep last=0x0F, m_axis_tready=1:
  - Egress starts 2 cycles after ingress tlast.
  - Data and tkeep identical; 8 beats contiguous; fifo_level peaks at 8 then returns to 0.
- Ingress stalls mid-frame (tvalid low for 20 cycles):
  - No egress beat appears until tlast is accepted; no gap inside the egress frame.
- Ten back-to-back 64-byte frames with m_axis_tready toggling 50%:
  - All 80 beats delivered in order.
  - tlast on every 8th beat; no drops.
- ADDR_W=4, 20-beat frame:
  - FSM enters DROP at beat 16; all 20 beats accepted; pkt_dropped pulses once.
  - No egress output; a following 4-beat frame passes intact.
- Egress held tready=0 with FIFO full of two committed frames:
  - s_axis_tready=0; no drop.
  - Releasing tready drains both frames, then accepts new input.
- TX_PKT_FIFO_DROP_BAD_EN defined, 3 frames with middle tuser=1 on tlast:
  - Only frames 1 and 3 emitted; one pkt_dropped pulse.
  - Undefined: all 3 emitted, m_axis_tuser=1 on frame 2 tlast.
